// File: rtl/usb_pkg.sv
// Shared USB definitions: packet types, PID nibbles, SYNC pattern, CRC16
// constants, line-state encodings and the TX FSM state type.
package usb_pkg;

  typedef enum logic [2:0] {
    PKT_NONE  = 3'd0,
    PKT_DATA0 = 3'd1,
    PKT_DATA1 = 3'd2,
    PKT_ACK   = 3'd3,
    PKT_NAK   = 3'd4,
    PKT_STALL = 3'd5
  } tx_packet_e;

  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [7:0] SYNC_BYTE = 8'h80;

  // Reflected form of x^16+x^15+x^2+1; the residual is what the register holds
  // after running data plus its transmitted (complemented) CRC through it.
  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

  // {D+, D-}
  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_e;

  function automatic logic pkt_legal(input logic [2:0] p);
    return (p >= 3'd1) && (p <= 3'd5);
  endfunction

  function automatic logic pkt_is_data(input logic [2:0] p);
    return (p == PKT_DATA0) || (p == PKT_DATA1);
  endfunction

  function automatic logic [7:0] pid_byte(input logic [2:0] p);
    logic [3:0] pid;
    case (p)
      PKT_DATA0: pid = PID_DATA0;
      PKT_DATA1: pid = PID_DATA1;
      PKT_ACK:   pid = PID_ACK;
      PKT_NAK:   pid = PID_NAK;
      default:   pid = PID_STALL;
    endcase
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_crc16.sv
// Serial USB CRC16 (reflected, LSB-first data).
// Ports: clk, rst (sync, active-high), clr_i (load init value), en_i (shift in
// data_bit_i), crc_o (current register, not complemented).
module usb_crc16
  import usb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic        data_bit_i,
  output logic [15:0] crc_o
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clr_i) begin
      crc_d = CRC16_INIT;
    end else if (en_i) begin
      crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ data_bit_i) ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC16_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmit engine: SYNC, PID, optional payload + CRC16, EOP,
// with bit stuffing and NRZI onto D+/D-.
// Ports: clk, rst (sync, active-high); tx_start/tx_packet/buffer_occupancy
// request a packet; get_tx_packet_data pops a byte that arrives on
// tx_packet_data one cycle later; dplus_out/dminus_out drive the line;
// tx_busy/tx_done/tx_error report status.
module usb_tx_encoder
  import usb_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int MAX_PAYLOAD  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic       dplus_out,
  output logic       dminus_out,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int                 CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [7:0]         MAX_PL   = 8'(MAX_PAYLOAD);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       ones_q, ones_d;
  logic [2:0]       pkt_q, pkt_d;
  logic [6:0]       bcnt_q, bcnt_d;
  logic [6:0]       fetched_q, fetched_d;
  logic [6:0]       sent_q, sent_d;
  logic [7:0]       pf_q, pf_d;
  logic [7:0]       data_q, data_d;
  logic             cap_q, cap_d;
  logic             get_q, get_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [1:0]       line_q, line_d;

  tx_state_e        nxt_state;
  logic [2:0]       nxt_idx;
  logic [7:0]       byte_cur;
  logic             nxt_bit;
  logic             crc_clr, crc_en, crc_bit;
  logic [15:0]      crc;

  usb_crc16 u_crc (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (crc_clr),
    .en_i       (crc_en),
    .data_bit_i (crc_bit),
    .crc_o      (crc)
  );

  function automatic logic [1:0] nrzi(input logic [1:0] cur, input logic b);
    return b ? cur : ((cur == LINE_J) ? LINE_K : LINE_J);
  endfunction

  function automatic logic stuffable(input tx_state_e s);
    return (s == ST_PID) || (s == ST_DATA) || (s == ST_CRC_LO) || (s == ST_CRC_HI);
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    ones_d    = ones_q;
    pkt_d     = pkt_q;
    bcnt_d    = bcnt_q;
    fetched_d = fetched_q;
    sent_d    = sent_q;
    pf_d      = cap_q ? tx_packet_data : pf_q;
    data_d    = data_q;
    cap_d     = get_q;
    get_d     = 1'b0;
    err_d     = 1'b0;
    done_d    = 1'b0;
    line_d    = line_q;
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    crc_bit   = 1'b0;
    nxt_state = state_q;
    nxt_idx   = idx_q;
    byte_cur  = 8'h00;
    nxt_bit   = 1'b0;

    if (state_q == ST_IDLE) begin
      if (tx_start) begin
        if (!pkt_legal(tx_packet) ||
            (pkt_is_data(tx_packet) && ({1'b0, buffer_occupancy} > MAX_PL))) begin
          err_d = 1'b1;
        end else begin
          // First SYNC bit goes on the line at the accepting edge.
          state_d   = ST_SYNC;
          cnt_d     = '0;
          idx_d     = 3'd0;
          ones_d    = 3'd0;
          pkt_d     = tx_packet;
          bcnt_d    = pkt_is_data(tx_packet) ? buffer_occupancy : 7'd0;
          fetched_d = 7'd0;
          sent_d    = 7'd0;
          crc_clr   = 1'b1;
          line_d    = nrzi(LINE_J, SYNC_BYTE[0]);
        end
      end
    end else if (cnt_q != CNT_LAST) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = '0;
      if (stuffable(state_q) && (ones_q == 3'd6)) begin
        // Stuffed 0: the byte position does not advance.
        ones_d = 3'd0;
        line_d = nrzi(line_q, 1'b0);
      end else begin
        case (state_q)
          ST_EOP_SE0: begin
            if (idx_q == 3'd0) begin
              nxt_idx = 3'd1;
            end else begin
              nxt_state = ST_EOP_J;
              nxt_idx   = 3'd0;
            end
          end
          ST_EOP_J: begin
            nxt_state = ST_IDLE;
            nxt_idx   = 3'd0;
          end
          default: begin
            if (idx_q != 3'd7) begin
              nxt_idx = idx_q + 3'd1;
            end else begin
              nxt_idx = 3'd0;
              case (state_q)
                ST_SYNC:   nxt_state = ST_PID;
                ST_PID:    nxt_state = !pkt_is_data(pkt_q) ? ST_EOP_SE0 :
                                       (bcnt_q != 7'd0)    ? ST_DATA : ST_CRC_LO;
                ST_DATA:   nxt_state = (sent_q < bcnt_q) ? ST_DATA : ST_CRC_LO;
                ST_CRC_LO: nxt_state = ST_CRC_HI;
                ST_CRC_HI: nxt_state = ST_EOP_SE0;
                default:   nxt_state = ST_IDLE;
              endcase
            end
          end
        endcase

        state_d = nxt_state;
        idx_d   = nxt_idx;

        // Pop one byte ahead: at PID bit 0 and at bit 0 of every data byte.
        if ((nxt_idx == 3'd0) && ((nxt_state == ST_PID) || (nxt_state == ST_DATA)) &&
            (fetched_q < bcnt_q)) begin
          get_d     = 1'b1;
          fetched_d = fetched_q + 7'd1;
        end
        if ((nxt_state == ST_DATA) && (nxt_idx == 3'd0)) begin
          sent_d = sent_q + 7'd1;
          data_d = pf_q;
        end

        case (nxt_state)
          ST_SYNC:   byte_cur = SYNC_BYTE;
          ST_PID:    byte_cur = pid_byte(pkt_q);
          ST_DATA:   byte_cur = (nxt_idx == 3'd0) ? pf_q : data_q;
          ST_CRC_LO: byte_cur = ~crc[7:0];
          ST_CRC_HI: byte_cur = ~crc[15:8];
          default:   byte_cur = 8'h00;
        endcase
        nxt_bit = byte_cur[nxt_idx];

        case (nxt_state)
          ST_SYNC: begin
            line_d = nrzi(line_q, nxt_bit);
            ones_d = 3'd0;
          end
          ST_PID, ST_DATA, ST_CRC_LO, ST_CRC_HI: begin
            line_d = nrzi(line_q, nxt_bit);
            ones_d = nxt_bit ? (ones_q + 3'd1) : 3'd0;
          end
          ST_EOP_SE0: line_d = LINE_SE0;
          ST_EOP_J:   line_d = LINE_J;
          default: begin
            line_d = LINE_J;
            done_d = 1'b1;
          end
        endcase

        if (nxt_state == ST_DATA) begin
          crc_en  = 1'b1;
          crc_bit = nxt_bit;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= 3'd0;
      ones_q    <= 3'd0;
      pkt_q     <= 3'd0;
      bcnt_q    <= 7'd0;
      fetched_q <= 7'd0;
      sent_q    <= 7'd0;
      cap_q     <= 1'b0;
      get_q     <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      line_q    <= LINE_J;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      ones_q    <= ones_d;
      pkt_q     <= pkt_d;
      bcnt_q    <= bcnt_d;
      fetched_q <= fetched_d;
      sent_q    <= sent_d;
      cap_q     <= cap_d;
      get_q     <= get_d;
      err_q     <= err_d;
      done_q    <= done_d;
      line_q    <= line_d;
    end
  end

  // Payload holding registers carry no control meaning and are not reset.
  always_ff @(posedge clk) begin
    pf_q   <= pf_d;
    data_q <= data_d;
  end

  assign get_tx_packet_data = get_q;
  assign dplus_out          = line_q[1];
  assign dminus_out         = line_q[0];
  assign tx_busy            = (state_q != ST_IDLE);
  assign tx_done            = done_q;
  assign tx_error           = err_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
module tb_usb_tx_encoder;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] buffer_occupancy = 7'd0;
  logic [7:0] tx_packet_data = 8'h00;
  logic       get_tx_packet_data, dplus_out, dminus_out, tx_busy, tx_done, tx_error;

  usb_tx_encoder #(.CLKS_PER_BIT(CPB), .MAX_PAYLOAD(64)) dut (
    .clk                (clk),
    .rst                (rst),
    .tx_start           (tx_start),
    .tx_packet          (tx_packet),
    .buffer_occupancy   (buffer_occupancy),
    .tx_packet_data     (tx_packet_data),
    .get_tx_packet_data (get_tx_packet_data),
    .dplus_out          (dplus_out),
    .dminus_out         (dminus_out),
    .tx_busy            (tx_busy),
    .tx_done            (tx_done),
    .tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int busy_cnt = 0, get_cnt = 0, err_cnt = 0, done_cnt = 0, rd = 0;
  logic [7:0] mem [0:7];

  // Data buffer model plus event counters.
  always @(posedge clk) begin
    if (tx_busy) busy_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done) done_cnt++;
    if (get_tx_packet_data) begin
      get_cnt++;
      tx_packet_data <= mem[rd[2:0]];
      rd++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  function automatic int stuff_model(input logic [7:0] q[$]);
    int ones, s;
    ones = 0; s = 0;
    foreach (q[k]) begin
      for (int i = 0; i < 8; i++) begin
        if (q[k][i]) begin
          ones++;
          if (ones == 6) begin s++; ones = 0; end
        end else begin
          ones = 0;
        end
      end
    end
    return s;
  endfunction

  task automatic clear_counters();
    busy_cnt = 0; get_cnt = 0; err_cnt = 0; done_cnt = 0; rd = 0;
  endtask

  task automatic run_pkt(input logic [2:0] pkt, input logic [6:0] occ,
                         input logic [3:0][7:0] d, input logic [7:0] exp_pid,
                         input string tag);
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    bit         raw[$];
    logic [1:0] prev, ls;
    logic [7:0] acc;
    logic [15:0] c;
    int n, nb, bad, ones, stuffs, stuffbad, bp, exp_stuff;
    bit is_data;

    is_data = (pkt == 3'd1) || (pkt == 3'd2);
    n = is_data ? int'(occ) : 0;
    for (int i = 0; i < 4; i++) mem[i] = d[i];
    exp_q.push_back(exp_pid);
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(d[i]);
      c = crc_upd(c, d[i]);
    end
    if (is_data) begin
      exp_q.push_back(~c[7:0]);
      exp_q.push_back(~c[15:8]);
    end
    exp_stuff = stuff_model(exp_q);

    @(negedge clk);
    clear_counters();
    tx_packet = pkt; buffer_occupancy = occ; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk({tag, " first SYNC bit K"}, {dplus_out, dminus_out}, 2'b01);
    chk({tag, " no error"}, tx_error, 1'b0);

    prev = 2'b10; nb = 0;
    ls = {dplus_out, dminus_out};
    while (ls != 2'b00 && nb < 400) begin
      raw.push_back(ls == prev);
      prev = ls; nb++;
      repeat (CPB) @(posedge clk);
      #1;
      ls = {dplus_out, dminus_out};
    end
    chk({tag, " EOP reached"}, (nb < 400), 1'b1);

    bad = 0;
    for (int i = 0; i < 2 * CPB; i++) begin
      if ({dplus_out, dminus_out} != 2'b00) bad++;
      @(posedge clk); #1;
    end
    for (int i = 0; i < CPB; i++) begin
      if ({dplus_out, dminus_out} != 2'b10) bad++;
      @(posedge clk); #1;
    end
    chk({tag, " EOP shape"}, bad, 0);
    chk({tag, " tx_done after EOP"}, {tx_done, tx_busy}, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " single tx_done"}, done_cnt, 1);
    chk({tag, " idle line J"}, {dplus_out, dminus_out}, 2'b10);

    ones = 0; stuffs = 0; stuffbad = 0; bp = 0; acc = 8'h00;
    for (int i = 0; i < raw.size(); i++) begin
      if (i >= 8 && ones == 6) begin
        stuffs++;
        if (raw[i]) stuffbad++;
        ones = 0;
        continue;
      end
      if (i >= 8) ones = raw[i] ? ones + 1 : 0;
      acc[bp] = raw[i];
      bp++;
      if (bp == 8) begin got.push_back(acc); bp = 0; end
    end

    chk({tag, " byte count"}, got.size(), exp_q.size() + 1);
    chk({tag, " SYNC byte"}, (got.size() > 0) ? got[0] : 8'hXX, 8'h80);
    for (int i = 0; i < exp_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i + 1), (i + 1 < got.size()) ? got[i + 1] : 8'hXX, exp_q[i]);
    chk({tag, " stuff count"}, stuffs, exp_stuff);
    chk({tag, " stuff bits zero"}, stuffbad, 0);
    if (is_data && got.size() == n + 4) begin
      c = 16'hFFFF;
      for (int i = 0; i < n + 2; i++) c = crc_upd(c, got[i + 2]);
      chk({tag, " CRC residual"}, c, 16'hB001);
    end
    chk({tag, " get pulses"}, get_cnt, n);
    chk({tag, " busy cycles"}, busy_cnt, (8 + 8 * exp_q.size() + exp_stuff + 3) * CPB);
    chk({tag, " no tx_error"}, err_cnt, 0);
  endtask

  task automatic run_err(input logic [2:0] pkt, input logic [6:0] occ, input string tag);
    @(negedge clk);
    clear_counters();
    tx_packet = pkt; buffer_occupancy = occ; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
    chk({tag, " err pulse"}, {tx_error, tx_busy, dplus_out, dminus_out}, 4'b1010);
    @(posedge clk); #1;
    chk({tag, " err cleared"}, {tx_error, tx_busy, dplus_out, dminus_out}, 4'b0010);
    repeat (4 * CPB) @(posedge clk);
    #1;
    chk({tag, " err once"}, err_cnt, 1);
    chk({tag, " no activity"}, busy_cnt + get_cnt, 0);
    chk({tag, " line J"}, {dplus_out, dminus_out}, 2'b10);
  endtask

  typedef struct packed {
    logic [2:0]       pkt;
    logic [6:0]       occ;
    logic [3:0][7:0]  d;
    logic [7:0]       pid;
    logic             err;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int w;
    tbl[0]  = '{pkt: 3'd3, occ: 7'd0,   d: 32'h0,         pid: 8'hD2, err: 1'b0};
    tbl[1]  = '{pkt: 3'd1, occ: 7'd0,   d: 32'h0,         pid: 8'hC3, err: 1'b0};
    tbl[2]  = '{pkt: 3'd2, occ: 7'd2,   d: 32'h00002B67,  pid: 8'h4B, err: 1'b0};
    tbl[3]  = '{pkt: 3'd1, occ: 7'd2,   d: 32'h00003FFF,  pid: 8'hC3, err: 1'b0};
    tbl[4]  = '{pkt: 3'd4, occ: 7'd0,   d: 32'h0,         pid: 8'h5A, err: 1'b0};
    tbl[5]  = '{pkt: 3'd5, occ: 7'd3,   d: 32'h0,         pid: 8'h1E, err: 1'b0};
    tbl[6]  = '{pkt: 3'd2, occ: 7'd4,   d: 32'h7EFFFF00,  pid: 8'h4B, err: 1'b0};
    tbl[7]  = '{pkt: 3'd1, occ: 7'd65,  d: 32'h0,         pid: 8'h00, err: 1'b1};
    tbl[8]  = '{pkt: 3'd0, occ: 7'd0,   d: 32'h0,         pid: 8'h00, err: 1'b1};
    tbl[9]  = '{pkt: 3'd7, occ: 7'd0,   d: 32'h0,         pid: 8'h00, err: 1'b1};
    tbl[10] = '{pkt: 3'd2, occ: 7'd127, d: 32'h0,         pid: 8'h00, err: 1'b1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset state", {dplus_out, dminus_out, tx_busy, tx_done, tx_error, get_tx_packet_data},
        6'b100000);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].err) run_err(tbl[i].pkt, tbl[i].occ, $sformatf("v%0d", i));
      else            run_pkt(tbl[i].pkt, tbl[i].occ, tbl[i].d, tbl[i].pid, $sformatf("v%0d", i));
    end

    // tx_start while busy must be ignored, even with an illegal type.
    @(negedge clk);
    clear_counters();
    tx_packet = 3'd3; buffer_occupancy = 7'd0; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (20) @(negedge clk);
    tx_packet = 3'd0; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    w = 0;
    while (tx_busy && w < 300) begin @(negedge clk); w++; end
    chk("busy ignore timeout", (w < 300), 1'b1);
    repeat (3) @(negedge clk);
    chk("busy ignore cycles", busy_cnt, 76);
    chk("busy ignore no error", err_cnt, 0);
    chk("busy ignore one done", done_cnt, 1);
    chk("busy ignore idle", {tx_busy, dplus_out, dminus_out}, 3'b010);

    // Reset in the middle of the payload.
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    @(negedge clk);
    clear_counters();
    tx_packet = 3'd2; buffer_occupancy = 7'd4; tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (75) @(negedge clk);
    chk("pre-reset gets", get_cnt, 2);
    chk("pre-reset busy", tx_busy, 1'b1);
    get_cnt = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset line J", {dplus_out, dminus_out}, 2'b10);
    chk("reset busy low", {tx_busy, get_tx_packet_data}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("reset no gets", get_cnt, 0);
    chk("reset stays idle", {tx_busy, dplus_out, dminus_out}, 3'b010);
    run_pkt(3'd3, 7'd0, 32'h0, 8'hD2, "post-reset ACK");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/usb_tx_encoder.md
Name: usb_tx_encoder

Overview:
Full-speed USB transmit engine on the buffer's TX side. On a start request it sends SYNC and PID. For data packets it then drains the payload byte-by-byte from data_buffer via get_tx_packet_data, appends CRC16, and sends EOP. Output is bit-stuffed, NRZI-encoded D+/D- line drive; the analog transceiver sits downstream.

Parameters:
CLKS_PER_BIT, 4, clk cycles per USB bit time (>=2)
MAX_PAYLOAD, 64, max data bytes per packet

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
tx_start  in  1  one-cycle request to send a packet; ignored while tx_busy
tx_packet  in  3  packet type: 1=DATA0, 2=DATA1, 3=ACK, 4=NAK, 5=STALL; others are illegal
buffer_occupancy  in  7  bytes available in data_buffer; sampled at tx_start
tx_packet_data  in  8  byte from data_buffer; valid the cycle after a get pulse
get_tx_packet_data  out  1  one-cycle pop request to data_buffer
dplus_out  out  1  D+ line level
dminus_out  out  1  D- line level
tx_busy  out  1  high from the cycle after an accepted tx_start until tx_done
tx_done  out  1  one-cycle pulse at end of EOP
tx_error  out  1  one-cycle pulse on a rejected start

Behaviour:
- Reset values: dplus_out=1, dminus_out=0 (idle J); all other outputs 0. Reset mid-packet returns the lines to J on the next edge with no further get pulses.
- Accepted start:
  - Occurs when tx_start=1 in IDLE.
  - Latches tx_packet, and byte_count=buffer_occupancy for DATA types.
  - tx_packet illegal, or DATA with occupancy>MAX_PAYLOAD: pulse tx_error the next cycle, stay IDLE, line untouched.
- FSM: IDLE -> SYNC -> PID -> (DATA -> CRC_LO -> CRC_HI, DATA types only) -> EOP_SE0 (2 bit times) -> EOP_J (1 bit time) -> IDLE with tx_done pulse.
  - DATA with byte_count=0 goes PID -> CRC_LO directly.
- Bit timing:
  - A bit counter runs 0..CLKS_PER_BIT-1.
  - The line changes only when the counter wraps.
  - The first SYNC bit appears on the line 1 cycle after the accepted start.
- Byte values (all bytes LSB first):
  - SYNC = 0x80.
  - PID = {~pid[3:0], pid[3:0]}: DATA0 0xC3, DATA1 0x4B, ACK 0xD2, NAK 0x5A, STALL 0x1E.
- Payload fetch:
  - Pulse get_tx_packet_data for exactly 1 cycle at the start of bit 0 of the PID byte (first byte), and at the start of bit 0 of each data byte while fetched < byte_count.
  - Capture tx_packet_data the following cycle into a prefetch register.
  - Exactly byte_count pulses per packet.
- CRC16:
  - Polynomial x^16+x^15+x^2+1, reflected, init 0xFFFF, computed over payload bits only.
  - Transmit the bitwise complement, low byte first, LSB first.
  - Zero-length payload gives CRC bytes 0x00 0x00.
- Bit stuffing:
  - Count consecutive 1 bits from the first PID bit through the last CRC bit; the counter is cleared in SYNC.
  - After six 1s, insert one 0 bit time; the inserted 0 resets the count.
  - A stuffed bit delays the fetch and byte sequencing by one bit time.
  - No stuff is inserted before EOP unless the 6th 1 was the final CRC bit; in that case the stuff bit is still sent.
- NRZI: data 0 toggles the line state (J<->K), data 1 holds it. J = (1,0), K = (0,1), SE0 = (0,0).
- tx_start during tx_busy is ignored and does not generate tx_error.

Decomposition:
- Package usb_pkg:
  - tx_packet type enum.
  - PID constants.
  - SYNC_BYTE.
  - CRC16_POLY, CRC16_INIT, CRC16_RESIDUAL.
  - Line-state encodings J/K/SE0.
- Sub-module usb_crc16: serial CRC with clear, enable, and data_bit inputs and a 16-bit crc output, reusable by the RX path.

Test Plan:
- ACK start -> NRZI line shows SYNC KJKJKJKK, then PID 0xD2, SE0 for 8 clks, J for 4 clks. tx_done fires 1 cycle later; 0 get pulses; tx_busy is high for (8+8+3)*4 cycles.
- DATA0 with occupancy=0 -> SYNC, 0xC3, CRC bytes 0x00 0x00, EOP; 0 get pulses.
- DATA1 with occupancy=2 and buffer bytes 0x67, 0x2B -> exactly 2 get pulses. Decoded line: 0x4B 0x67 0x2B, then CRC equal to a reference model.
- DATA0 with payload 0xFF, 0x3F -> a stuffed 0 after the 6th consecutive 1. The receive-side decoder recovers 0xFF 0x3F, and the total bit times grow by the stuff count.
- Occupancy=65, or tx_packet=0 -> tx_error pulses once, lines stay J, tx_busy stays 0. A second tx_start while busy is ignored.
- rst asserted mid-payload -> next edge lines=J, tx_busy=0, no get pulses. A fresh ACK then transmits correctly.
